// File: rtl/reqack_arbiter.sv
// Three-channel round-robin request/acknowledge arbiter. It raises a sticky
// per-channel interrupt when a request waits too long or an owner holds too long.
module reqack_arbiter #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned MAX_WAIT = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] done,
  input  logic [NUM_CH-1:0] intr_clr,
  output logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] intrpt,
  output logic              busy
);

  localparam int unsigned      CNT_W    = 4;
  localparam int unsigned      IDX_W    = 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WAIT_PRE = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] wait_cnt [NUM_CH];

  logic              grant_c;
  logic [IDX_W-1:0]  winner_c;
  logic              release_c;
  logic [NUM_CH-1:0] wait_set_c;
  logic [NUM_CH-1:0] hold_set_c;

  // Round-robin pick: search starts one past the last owner.
  always_comb begin
    int unsigned cand;
    grant_c  = 1'b0;
    winner_c = last;
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = (32'(last) + k) % NUM_CH;
      if (!grant_c && req[IDX_W'(cand)]) begin
        grant_c  = 1'b1;
        winner_c = IDX_W'(cand);
      end
    end
  end

  // Owner leaves on done or abandon; hold-timeout forces release and flags it.
  always_comb begin
    release_c  = 1'b0;
    hold_set_c = '0;
    if (state == BUSY) begin
      if (done[owner] || !req[owner]) begin
        release_c = 1'b1;
      end else if (hold_cnt == HOLD_LIM) begin
        release_c  = 1'b1;
        hold_set_c = NUM_CH'(1) << owner;
      end
    end
  end

  // A wait episode flags exactly once, on the step that reaches MAX_WAIT.
  always_comb begin
    wait_set_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wait_set_c[i] = req[i] && !ack[i] && (wait_cnt[i] == WAIT_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= LAST_RST;
      hold_cnt <= '0;
      ack      <= '0;
      intrpt   <= '0;
      busy     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      intrpt <= (intrpt & ~intr_clr) | wait_set_c | hold_set_c;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!req[i] || ack[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (enb && grant_c) begin
            state    <= BUSY;
            owner    <= winner_c;
            ack      <= NUM_CH'(1) << winner_c;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_c) begin
            state <= IDLE;
            ack   <= '0;
            busy  <= 1'b0;
            last  <= owner;
          end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
